// File: rtl/md_stall_ctrl.sv
// md_stall_ctrl: sequences the multi-cycle mul/div unit beside the X stage.
// Launches the unit, freezes PC/FD/DX and bubbles XM while it runs, then
// hands the captured result to the XM latch for one cycle. A watchdog
// aborts operations whose ready never arrives.
// Optional feature macro: MD_RSTATUS_EN (exception writes code to r30).
module md_stall_ctrl #(
   parameter int unsigned TIMEOUT = 40,
   parameter int unsigned CNT_W   = 6
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [4:0]  opcode_X,
   input  logic [4:0]  aluop_X,
   input  logic        flush,
   input  logic        md_rdy,
   input  logic        md_exc,
   input  logic [31:0] md_data,
   output logic        ctrl_MULT,
   output logic        ctrl_DIV,
   output logic        stall,
   output logic        bubble_XM,
   output logic        md_wb_valid,
   output logic [31:0] md_result,
   output logic        md_wr_rstatus,
   output logic        md_timeout,
   output logic        busy
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [31:0]       md_result_q, md_result_d;
   logic              timeout_q, timeout_d;
   logic              armed_q, armed_d;

   logic is_mul, is_div, launch;

`ifdef MD_RSTATUS_EN
   logic exc_q, exc_d;
   logic op_div_q, op_div_d;
`endif

   // Decode mul/div in X; launch only from IDLE, never in the cycle reset releases
   assign is_mul = (opcode_X == 5'b00000) && (aluop_X == 5'b00110);
   assign is_div = (opcode_X == 5'b00000) && (aluop_X == 5'b00111);
   assign launch = (state_q == S_IDLE) && armed_q && (is_mul || is_div) && !flush;

   // Next-state, watchdog and result-capture logic
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      md_result_d = md_result_q;
      timeout_d   = timeout_q;
      armed_d     = 1'b1;
`ifdef MD_RSTATUS_EN
      exc_d       = exc_q;
      op_div_d    = op_div_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (launch) begin
               state_d = S_RUN;
               cnt_d   = '0;
`ifdef MD_RSTATUS_EN
               op_div_d = is_div;
`endif
            end
         end
         S_RUN: begin
            if (cnt_q != CNT_W'(TIMEOUT)) begin
               cnt_d = cnt_q + CNT_W'(1);
            end
            if (flush) begin
               // Killed instruction: drop the operation, ignore its late ready
               state_d = S_IDLE;
            end else if (md_rdy) begin
               state_d     = S_DONE;
               md_result_d = md_data;
`ifdef MD_RSTATUS_EN
               exc_d = md_exc;
               if (md_exc) begin
                  md_result_d = op_div_q ? 32'd5 : 32'd4;
               end
`endif
            end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
               state_d     = S_DONE;
               timeout_d   = 1'b1;
               md_result_d = '0;
`ifdef MD_RSTATUS_EN
               exc_d = 1'b0;
`endif
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State and datapath registers
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         md_result_q <= '0;
         timeout_q   <= 1'b0;
         armed_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         md_result_q <= md_result_d;
         timeout_q   <= timeout_d;
         armed_q     <= armed_d;
      end
   end

`ifdef MD_RSTATUS_EN
   // Exception flag and operation type for the r30 status writeback
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         exc_q    <= 1'b0;
         op_div_q <= 1'b0;
      end else begin
         exc_q    <= exc_d;
         op_div_q <= op_div_d;
      end
   end

   assign md_wr_rstatus = (state_q == S_DONE) && exc_q;
`else
   logic unused_md_exc;
   assign unused_md_exc = md_exc;
   assign md_wr_rstatus = 1'b0;
`endif

   // Pipeline control: start pulses and stall are same-cycle on launch
   assign ctrl_MULT   = launch && is_mul;
   assign ctrl_DIV    = launch && is_div;
   assign stall       = launch || (state_q == S_RUN);
   assign bubble_XM   = launch || (state_q == S_RUN);
   assign md_wb_valid = (state_q == S_DONE) && !flush;
   assign busy        = (state_q != S_IDLE);
   assign md_result   = md_result_q;
   assign md_timeout  = timeout_q;

endmodule

// File: tb/tb_md_stall_ctrl.sv
// tb_md_stall_ctrl: self-checking bench for md_stall_ctrl. Each operation's
// expected waveform is derived from its latency, flush point and outcome.
// Honours MD_RSTATUS_EN to match the optional status writeback.
module tb_md_stall_ctrl;

   localparam int unsigned TIMEOUT = 40;

   logic        clock = 1'b0;
   logic        reset;
   logic [4:0]  opcode_X;
   logic [4:0]  aluop_X;
   logic        flush;
   logic        md_rdy;
   logic        md_exc;
   logic [31:0] md_data;
   logic        ctrl_MULT;
   logic        ctrl_DIV;
   logic        stall;
   logic        bubble_XM;
   logic        md_wb_valid;
   logic [31:0] md_result;
   logic        md_wr_rstatus;
   logic        md_timeout;
   logic        busy;

   md_stall_ctrl #(.TIMEOUT(TIMEOUT), .CNT_W(6)) dut (
      .clock         (clock),
      .reset         (reset),
      .opcode_X      (opcode_X),
      .aluop_X       (aluop_X),
      .flush         (flush),
      .md_rdy        (md_rdy),
      .md_exc        (md_exc),
      .md_data       (md_data),
      .ctrl_MULT     (ctrl_MULT),
      .ctrl_DIV      (ctrl_DIV),
      .stall         (stall),
      .bubble_XM     (bubble_XM),
      .md_wb_valid   (md_wb_valid),
      .md_result     (md_result),
      .md_wr_rstatus (md_wr_rstatus),
      .md_timeout    (md_timeout),
      .busy          (busy)
   );

   always #5 clock = ~clock;

   int          n_checks = 0;
   int          n_errors = 0;
   int          cyc = 0;
   logic [31:0] exp_result = '0;
   logic        exp_timeout = 1'b0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0h exp=%0h cyc=%0d", tag, got, exp, cyc);
      end
   endtask

   // Check one cycle at the falling edge, then advance past the rising edge
   task automatic step(input logic e_mul, input logic e_div, input logic e_stall,
                       input logic e_busy, input logic e_wb, input logic e_wr);
      @(negedge clock);
      chk("ctrl_MULT", 32'(ctrl_MULT), 32'(e_mul));
      chk("ctrl_DIV", 32'(ctrl_DIV), 32'(e_div));
      chk("stall", 32'(stall), 32'(e_stall));
      chk("bubble_XM", 32'(bubble_XM), 32'(e_stall));
      chk("busy", 32'(busy), 32'(e_busy));
      chk("md_wb_valid", 32'(md_wb_valid), 32'(e_wb));
      chk("md_wr_rstatus", 32'(md_wr_rstatus), 32'(e_wr));
      chk("md_result", md_result, exp_result);
      chk("md_timeout", 32'(md_timeout), 32'(exp_timeout));
      @(posedge clock);
      #1;
      cyc++;
   endtask

   task automatic set_nop();
      opcode_X = 5'($urandom);
      aluop_X  = 5'($urandom);
      if (opcode_X == 5'd0 && (aluop_X == 5'd6 || aluop_X == 5'd7)) aluop_X = 5'd0;
   endtask

   // Idle cycles with non-mul/div in X and random noise on the unit handshake
   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         set_nop();
         flush   = 1'($urandom);
         md_rdy  = 1'($urandom);
         md_exc  = 1'($urandom);
         md_data = $urandom;
         step(0, 0, 0, 0, 0, 0);
      end
      flush  = 1'b0;
      md_rdy = 1'b0;
   endtask

   // One operation: n = ready latency in RUN cycles (0 = never ready),
   // flush_k > 0 flushes in that RUN cycle, flush_k < 0 flushes in DONE
   task automatic run_op(input logic is_div, input int n, input int flush_k,
                         input logic exc, input logic [31:0] data, output int launch_cyc);
      int   last;
      logic wr;
      opcode_X = 5'd0;
      aluop_X  = is_div ? 5'd7 : 5'd6;
      flush    = 1'b0;
      md_rdy   = 1'b0;
      md_exc   = 1'($urandom);
      md_data  = $urandom;
      launch_cyc = cyc;
      step(!is_div, is_div, 1, 0, 0, 0);
      if (flush_k > 0) last = flush_k;
      else if (n == 0) last = TIMEOUT;
      else last = n;
      for (int i = 1; i <= last; i++) begin
         md_data = $urandom;
         md_exc  = 1'($urandom);
         md_rdy  = (n != 0) && (i == n);
         flush   = (flush_k > 0) && (i == flush_k);
         if (md_rdy) begin
            md_data = data;
            md_exc  = exc;
         end
         step(0, 0, 1, 1, 0, 0);
      end
      if (flush_k > 0) begin
         // Aborted: back to idle, and the unit's late ready must be ignored
         set_nop();
         flush  = 1'b0;
         md_rdy = 1'b0;
         step(0, 0, 0, 0, 0, 0);
         md_rdy  = 1'b1;
         md_data = $urandom;
         step(0, 0, 0, 0, 0, 0);
         md_rdy = 1'b0;
         return;
      end
      wr = 1'b0;
      if (n == 0) begin
         exp_result  = '0;
         exp_timeout = 1'b1;
      end else begin
         exp_result = data;
`ifdef MD_RSTATUS_EN
         if (exc) begin
            exp_result = is_div ? 32'd5 : 32'd4;
            wr = 1'b1;
         end
`endif
      end
      flush   = (flush_k < 0);
      md_rdy  = 1'($urandom);
      md_exc  = 1'($urandom);
      md_data = $urandom;
      step(0, 0, 0, 1, !(flush_k < 0), wr);
      flush  = 1'b0;
      md_rdy = 1'b0;
   endtask

   initial begin
      int l1, l2, n, mode, k;
      logic dv;
      reset   = 1'b0;
      flush   = 1'b0;
      md_rdy  = 1'b0;
      md_exc  = 1'b0;
      md_data = '0;
      opcode_X = 5'd0;
      aluop_X  = 5'd6;
      // In reset with a mul in X: everything quiet
      step(0, 0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0, 0);
      reset = 1'b1;
      // Release cycle with the mul still in X: no start pulse
      step(0, 0, 0, 0, 0, 0);
      idle(2);

      // mul, ready after 16 RUN cycles
      run_op(1'b0, 16, 0, 1'b0, 32'd42, l1);
      idle(2);

      // Back-to-back divs, 32-cycle latency each
      run_op(1'b1, 32, 0, 1'b0, 32'h1234_5678, l1);
      run_op(1'b1, 32, 0, 1'b0, 32'h0BAD_F00D, l2);
      chk("div_spacing", 32'(l2 - l1), 32'd34);
      idle(2);

      // div with exception
      run_op(1'b1, 5, 0, 1'b1, 32'hDEAD_BEEF, l1);
      idle(1);

      // flush with mul/div in IDLE suppresses launch
      opcode_X = 5'd0;
      aluop_X  = 5'd7;
      flush    = 1'b1;
      step(0, 0, 0, 0, 0, 0);
      flush = 1'b0;
      // flush in RUN cycle 3
      run_op(1'b0, 10, 3, 1'b0, 32'h5555_AAAA, l1);
      idle(1);

      // Reset mid-RUN
      opcode_X = 5'd0;
      aluop_X  = 5'd6;
      step(1, 0, 1, 0, 0, 0);
      step(0, 0, 1, 1, 0, 0);
      step(0, 0, 1, 1, 0, 0);
      reset = 1'b0;
      #1;
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_stall", 32'(stall), 32'd0);
      exp_result  = '0;
      exp_timeout = 1'b0;
      step(0, 0, 0, 0, 0, 0);
      reset = 1'b1;
      step(0, 0, 0, 0, 0, 0);
      idle(2);

      // Watchdog: ready never arrives
      run_op(1'b0, 0, 0, 1'b0, 32'd0, l1);
      idle(2);

      // Random operations; timeout must stay sticky throughout
      for (int t = 0; t < 30; t++) begin
         dv   = 1'($urandom);
         n    = int'($urandom_range(1, 20));
         mode = int'($urandom_range(0, 5));
         k    = 0;
         if (mode == 0) k = int'($urandom_range(1, n));
         else if (mode == 1) k = -1;
         else if (mode == 2) begin
            opcode_X = 5'd0;
            aluop_X  = dv ? 5'd7 : 5'd6;
            flush    = 1'b1;
            step(0, 0, 0, 0, 0, 0);
            flush = 1'b0;
         end
         run_op(dv, n, k, 1'($urandom), $urandom, l1);
         if ($urandom_range(0, 1) == 0) idle(int'($urandom_range(1, 3)));
      end
      idle(1);

      // Reset clears the sticky timeout
      reset = 1'b0;
      exp_result  = '0;
      exp_timeout = 1'b0;
      step(0, 0, 0, 0, 0, 0);
      reset = 1'b1;
      idle(1);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/md_stall_ctrl.md
Name: md_stall_ctrl

Overview:
- Sequences the multi-cycle multiply/divide unit for the 5-stage pipeline.
- Sits beside the X stage. Detects mul/div in DX and launches the unit with a one-cycle start pulse.
- Freezes PC/FD/DX and bubbles XM until the unit reports ready, then hands the captured result to the XM latch for one cycle.
- Runs a watchdog counter on every operation.

Parameters:
TIMEOUT, 40, max RUN cycles before md_timeout sets (must be >= 2)
CNT_W, 6, watchdog counter width (2^CNT_W > TIMEOUT)

Ports:
clock  in  1  master clock, rising edge
reset  in  1  asynchronous, active-low; 0 = reset
opcode_X  in  5  IR_X[31:27]
aluop_X  in  5  IR_X[6:2]
flush  in  1  kill instruction in X (branch/jump taken)
md_rdy  in  1  multdiv result ready (single-cycle pulse)
md_exc  in  1  multdiv exception, valid with md_rdy
md_data  in  32  multdiv result, valid with md_rdy
ctrl_MULT  out  1  multiply start pulse
ctrl_DIV  out  1  divide start pulse
stall  out  1  hold PC, FD, DX enables low
bubble_XM  out  1  XM latch loads nop
md_wb_valid  out  1  XM latch takes md_result instead of ALU_out
md_result  out  32  captured result
md_wr_rstatus  out  1  writeback target is r30, not rd
md_timeout  out  1  sticky watchdog error
busy  out  1  state != IDLE

Behaviour:
- is_md = (opcode_X == 5'b00000) && (aluop_X == 5'b00110 [mul] || aluop_X == 5'b00111 [div]).
- FSM states: IDLE, RUN, DONE. Reset (reset == 0, async) forces:
  - state = IDLE, cnt = 0
  - md_result = 0, exc_q = 0, md_timeout = 0
  - all outputs 0
- IDLE:
  - If is_md && !flush: combinationally pulse ctrl_MULT (mul) or ctrl_DIV (div) this cycle; assert stall = 1 and bubble_XM = 1; next state RUN, cnt <= 0.
  - Otherwise all outputs 0 and state stays IDLE.
  - Never pulse both start signals.
- RUN:
  - stall = 1, bubble_XM = 1, start pulses 0.
  - cnt increments and saturates at TIMEOUT.
  - If md_rdy: capture md_result <= md_data and exc_q <= md_exc; next state DONE.
  - Else if cnt == TIMEOUT-1: set md_timeout (sticky until reset); md_result <= 0; next state DONE.
  - md_rdy is ignored in IDLE and DONE.
- DONE:
  - stall = 0, bubble_XM = 0, md_wb_valid = 1 for exactly one cycle; next state IDLE.
  - Starts are never issued from DONE, even though X still holds the mul/div this cycle.
  - Back-to-back mul/div: the DONE -> IDLE -> launch sequence gives exactly one non-stalled cycle between operations.
- flush:
  - IDLE: suppresses launch.
  - RUN: aborts; next state IDLE, no writeback, stall drops the following cycle. The unit's later md_rdy is ignored.
  - DONE: md_wb_valid is forced to 0.
- Latency: launch cycle + N RUN cycles until md_rdy + 1 DONE cycle. Total stall cycles = N + 1.
- md_result holds its value outside DONE. Consumers qualify it with md_wb_valid.
- Reset mid-operation returns to IDLE immediately. No start pulse is issued on reset release.

Optional Feature:
MD_RSTATUS_EN
- Defined: in DONE with exc_q = 1, md_wr_rstatus = 1 and md_result = 32'd4 for mul or 32'd5 for div. The operation type is latched at launch.
- Not defined: md_wr_rstatus tied to 0; md_result = captured md_data regardless of md_exc; exc_q logic removed.

Test Plan:
1. Reset low mid-RUN -> busy = 0, stall = 0 within the same cycle; no ctrl_MULT on release.
2. mul in X (opcode 0, aluop 00110), md_rdy + md_data = 32'd42 after 16 cycles:
   - ctrl_MULT pulses 1 cycle; stall is high for 17 cycles.
   - DONE cycle: md_wb_valid = 1, md_result = 42.
3. Two back-to-back divs, each with md_rdy after 32 cycles:
   - Two ctrl_DIV pulses separated by exactly 34 cycles (33 stall cycles + 1 non-stalled cycle).
   - Two md_wb_valid pulses.
4. div with md_exc = 1 at md_rdy:
   - With MD_RSTATUS_EN: md_wr_rstatus = 1, md_result = 5.
   - Without: md_wr_rstatus = 0, md_result = md_data.
5. mul launched with md_rdy never asserted (TIMEOUT = 40):
   - md_timeout rises after 40 RUN cycles; one md_wb_valid with md_result = 0.
   - md_timeout stays 1 until reset.
6. flush with is_md in IDLE -> no start pulse. flush in RUN cycle 3 -> IDLE next cycle; a later md_rdy yields no md_wb_valid.
